// File: rtl/trivium_pkg.sv
// trivium_pkg: command encodings, state segment widths and defaults shared by the Trivium UART block.
package trivium_pkg;
    typedef enum logic [1:0] {CMD_KEY = 2'd0, CMD_IV = 2'd1, CMD_INIT = 2'd2, CMD_PT = 2'd3} cmd_t;
    localparam int S1_W = 93;
    localparam int S2_W = 84;
    localparam int S3_W = 111;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_WARMUP_CYCLES = 1152;
    function automatic logic [79:0] rev80(input logic [79:0] x);
        logic [79:0] r;
        for (int i = 0; i < 80; i++) r[i] = x[79-i];
        return r;
    endfunction
endpackage

// File: rtl/trivium_core.sv
// trivium_core: 288-bit Trivium state with load, single-step update and combinational keystream bit z.
module trivium_core
    import trivium_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [79:0] key,
    input  logic [79:0] iv,
    output logic        z
);
    localparam int B2 = S1_W;
    localparam int B3 = S1_W + S2_W;
    localparam int N = B3 + S3_W;
    // s[i] holds Trivium bit s_i, so the textbook taps read directly
    logic [N:1] s;
    logic t1, t2, t3;
    always_comb begin
        t1 = s[66] ^ s[B2];
        t2 = s[162] ^ s[B3];
        t3 = s[243] ^ s[N];
        z = t1 ^ t2 ^ t3;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) s <= '0;
        else if (load) s <= {3'b111, 108'b0, 4'b0, rev80(iv), 13'b0, rev80(key)};
        else if (step) s <= {s[N-1:B3+1], t2 ^ (s[175] & s[176]) ^ s[264],
                             s[B3-1:B2+1], t1 ^ (s[91] & s[92]) ^ s[171],
                             s[B2-1:1], t3 ^ (s[286] & s[287]) ^ s[69]};
endmodule

// File: rtl/trivium_uart_top.sv
// trivium_uart_top: byte-wide key/IV/plaintext loader, Trivium encryption and UART 8N1 ciphertext output.
module trivium_uart_top
    import trivium_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, KS = 2'd2, TX = 2'd3;
    localparam int CW = $clog2(WARMUP_CYCLES > CLKS_PER_BIT ? WARMUP_CYCLES : CLKS_PER_BIT) + 1;
    logic [1:0] state;
    logic [2:0] stb_sync;
    logic [CW-1:0] cnt;
    logic [3:0] bit_idx;
    logic [79:0] key, iv;
    logic [7:0] pt, ks;
    logic [8:0] sh;
    logic tx, init_done, pulse, z, load, unused_ok;
    cmd_t cmd;
    assign cmd = cmd_t'(uio_in[1:0]);
    assign pulse = stb_sync[1] & ~stb_sync[2];
    assign load = pulse && state == IDLE && cmd == CMD_INIT;
    assign uo_out = {4'b0, init_done, state == TX, state == IDLE, tx};
    assign uio_out = '0;
    assign uio_oe = '0;
    assign unused_ok = ^{ena, uio_in[7:3]};
    trivium_core u_core (
        .clk(clk), .rst(rst), .load(load), .step(state == INIT || state == KS),
        .key(key), .iv(iv), .z(z)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            stb_sync <= '0;
            cnt <= '0;
            bit_idx <= '0;
            key <= '0;
            iv <= '0;
            pt <= '0;
            ks <= '0;
            sh <= '1;
            tx <= 1'b1;
            init_done <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[1:0], uio_in[2]};
            case (state)
                IDLE: if (pulse) begin
                    if (cmd == CMD_KEY) key <= {key[71:0], ui_in};
                    if (cmd == CMD_IV) iv <= {iv[71:0], ui_in};
                    if (cmd == CMD_INIT) begin
                        state <= INIT;
                        cnt <= '0;
                        init_done <= 1'b0;
                    end
                    if (cmd == CMD_PT && init_done) begin
                        state <= KS;
                        cnt <= '0;
                        pt <= ui_in;
                    end
                end
                INIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WARMUP_CYCLES - 1)) begin
                        state <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                KS: begin
                    ks <= {ks[6:0], z};
                    cnt <= cnt + CW'(1);
                    // eighth keystream bit arrives this cycle, so the start bit goes out now
                    if (cnt == CW'(7)) begin
                        state <= TX;
                        tx <= 1'b0;
                        sh <= {1'b1, pt ^ {ks[6:0], z}};
                        cnt <= '0;
                        bit_idx <= '0;
                    end
                end
                default: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt <= '0;
                    if (bit_idx == 4'd9) state <= IDLE;
                    else begin
                        tx <= sh[0];
                        sh <= {1'b1, sh[8:1]};
                        bit_idx <= bit_idx + 4'd1;
                    end
                end else cnt <= cnt + CW'(1);
            endcase
        end
endmodule

// File: tb/tb_trivium_uart_top.sv
// tb_trivium_uart_top: scoreboard bench with a bit-level Trivium model and a UART receiver on uo_out[0].
module tb_trivium_uart_top;
    localparam int CPB = 16;
    localparam int WARM = 1152;
    logic clk = 0, rst = 0, ena = 1;
    logic [7:0] ui_in = 0, uio_in = 0;
    logic [7:0] uo_out, uio_out, uio_oe;
    int vectors = 0, errors = 0;
    logic [7:0] key_b[10], iv_b[10];
    bit ms[1:288];
    logic [7:0] exp_q[$];
    logic [8:0] rx_q[$];
    bit rx_en = 0;

    always #5 clk = ~clk;

    trivium_uart_top #(.CLKS_PER_BIT(CPB), .WARMUP_CYCLES(WARM)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    initial begin
        logic [7:0] b;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rx_en && !rst && uo_out[0] == 1'b0) begin
                aborted = 0;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (rst) aborted = 1;
                    end
                    b[i] = uo_out[0];
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (rst) aborted = 1;
                end
                if (!aborted) rx_q.push_back({uo_out[0], b});
            end
        end
    end

    task automatic model_step(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic model_init();
        bit z;
        for (int i = 1; i <= 288; i++) ms[i] = 0;
        for (int j = 0; j < 80; j++) begin
            ms[j+1] = key_b[j/8][7-j%8];
            ms[94+j] = iv_b[j/8][7-j%8];
        end
        ms[286] = 1;
        ms[287] = 1;
        ms[288] = 1;
        repeat (WARM) model_step(z);
    endtask

    task automatic model_byte(output logic [7:0] b);
        bit z;
        b = 0;
        for (int i = 0; i < 8; i++) begin
            model_step(z);
            b = {b[6:0], z};
        end
    endtask

    task automatic strobe(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clk);
        ui_in = data;
        uio_in = {5'b0, 1'b1, cmd};
        repeat (4) @(negedge clk);
        uio_in[2] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_init(output int low);
        for (int i = 0; i < 10; i++) begin
            strobe(2'd0, key_b[i]);
            strobe(2'd1, iv_b[i]);
        end
        @(negedge clk);
        uio_in = {5'b0, 1'b1, 2'd2};
        low = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 4) uio_in[2] = 1'b0;
            if (uo_out[1] == 1'b0) low++;
            else if (low > 0) break;
        end
        uio_in[2] = 1'b0;
        model_init();
    endtask

    task automatic send_pt(input logic [7:0] pt, input bit push);
        logic [7:0] kb;
        if (push) begin
            model_byte(kb);
            exp_q.push_back(pt ^ kb);
        end
        strobe(2'd3, pt);
    endtask

    task automatic run_frame(output logic [8:0] got, output bit ok, output int busy);
        busy = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (uo_out[2]) busy++;
            else if (busy > 0) break;
        end
        repeat (2) @(negedge clk);
        ok = rx_q.size() > 0;
        got = ok ? rx_q.pop_front() : 9'h0;
    endtask

    task automatic test_reset();
        int lows;
        rst = 1;
        #20;
        vectors++;
        if (uo_out !== 8'h03) begin errors++; $display("FAIL reset_uo_out got %h want 03", uo_out); end
        vectors++;
        if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_uio_oe got %h want 00", uio_oe); end
        vectors++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
        @(negedge clk);
        rst = 0;
        rx_en = 1;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0) begin errors++; $display("FAIL idle_line low_cycles %0d want 0", lows); end
    endtask

    task automatic test_pt_before_init();
        int bad;
        send_pt(8'hA5, 0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1 || uo_out[1] !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL pt_before_init bad_cycles %0d want 0", bad); end
        vectors++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL pt_before_init frames %0d want 0", rx_q.size()); end
    endtask

    task automatic test_init_zero();
        int low;
        for (int i = 0; i < 10; i++) begin key_b[i] = 8'h00; iv_b[i] = 8'h00; end
        do_init(low);
        vectors++;
        if (low != WARM) begin errors++; $display("FAIL init_ready_low got %0d want %0d", low, WARM); end
        vectors++;
        if (uo_out[3] !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", uo_out[3]); end
    endtask

    task automatic test_encrypt_zero();
        logic [8:0] got;
        logic [7:0] e;
        bit ok;
        int busy;
        send_pt(8'h00, 1);
        run_frame(got, ok, busy);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || got !== {1'b1, e}) begin errors++; $display("FAIL ks0_byte got %h want %h ok %0d", got, {1'b1, e}, ok); end
        vectors++;
        if (busy != 10 * CPB) begin errors++; $display("FAIL frame_len got %0d want %0d", busy, 10 * CPB); end
    endtask

    task automatic test_roundtrip();
        logic [8:0] got;
        logic [7:0] e, c;
        bit ok;
        int busy, low;
        for (int i = 0; i < 10; i++) begin key_b[i] = 8'(i * 37 + 5); iv_b[i] = 8'(8'hC3 ^ (i * 11)); end
        do_init(low);
        vectors++;
        if (low != WARM) begin errors++; $display("FAIL reinit_ready_low got %0d want %0d", low, WARM); end
        send_pt(8'h5A, 1);
        run_frame(got, ok, busy);
        e = exp_q.pop_front();
        c = got[7:0];
        vectors++;
        if (!ok || got !== {1'b1, e}) begin errors++; $display("FAIL enc_5a got %h want %h ok %0d", got, {1'b1, e}, ok); end
        do_init(low);
        send_pt(c, 1);
        run_frame(got, ok, busy);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || got !== {1'b1, e}) begin errors++; $display("FAIL dec_model got %h want %h ok %0d", got, {1'b1, e}, ok); end
        vectors++;
        if (got[7:0] !== 8'h5A) begin errors++; $display("FAIL dec_5a got %h want 5a", got[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got;
        logic [7:0] e;
        bit ok;
        int busy, low;
        for (int i = 0; i < 10; i++) begin key_b[i] = 8'h00; iv_b[i] = 8'h00; end
        do_init(low);
        for (int k = 0; k < 2; k++) begin
            send_pt(8'h00, 1);
            run_frame(got, ok, busy);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || got !== {1'b1, e}) begin errors++; $display("FAIL b2b_byte%0d got %h want %h ok %0d", k, got, {1'b1, e}, ok); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] got;
        logic [7:0] e;
        bit ok;
        int busy, low, extra;
        send_pt(8'h3C, 0);
        for (int c = 0; c < 100 && !uo_out[2]; c++) @(negedge clk);
        repeat (5 * CPB + 2) @(negedge clk);
        rst = 1;
        #1;
        vectors++;
        if (uo_out !== 8'h03) begin errors++; $display("FAIL mid_frame_rst uo_out got %h want 03", uo_out); end
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (200) @(negedge clk);
        rx_q.delete();
        do_init(low);
        send_pt(8'h81, 1);
        for (int c = 0; c < 100 && !uo_out[2]; c++) @(negedge clk);
        strobe(2'd3, 8'hFF);
        run_frame(got, ok, busy);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || got !== {1'b1, e}) begin errors++; $display("FAIL after_rst_byte got %h want %h ok %0d", got, {1'b1, e}, ok); end
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (uo_out[2]) extra++;
        end
        vectors++;
        if (extra != 0 || rx_q.size() != 0) begin errors++; $display("FAIL busy_strobe extra_busy %0d frames %0d want 0 0", extra, rx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pt_before_init();
        test_init_zero();
        test_encrypt_zero();
        test_roundtrip();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/trivium_uart_top.md
Name: trivium_uart_top

Overview:
- Tiny-Tapeout-style top that encrypts plaintext bytes with the Trivium stream cipher and sends ciphertext bytes out as UART 8N1 on uo_out[0].
- Key and IV (80 bits each) and plaintext are loaded byte-wide through ui_in, with a command/strobe on uio_in.
- Downstream, a UART receiver recovers the ciphertext bytes from uo_out[0].

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (>=2).
- WARMUP_CYCLES, 1152, Trivium initialisation rounds (4*288).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  design selected; ignored, the block is always active.
- ui_in  input  8  data byte (key / IV / plaintext).
- uio_in  input  8  [1:0] cmd (0 key byte, 1 IV byte, 2 start init, 3 plaintext byte); [2] strobe; [7:3] unused.
- uo_out  output  8  [0] UART TX serial; [1] ready; [2] tx_busy; [3] init_done; [7:4] 0.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all inputs).

Behaviour:
- Reset values: uo_out[0]=1 (idle line); ready=1; tx_busy=0; init_done=0; key and IV registers 0; 288-bit state 0; uio_out=uio_oe=0.
- Strobe handling:
  - uio_in[2] is synchronised through 2 flops; rising-edge detect gives a one-cycle cmd pulse.
  - cmd and ui_in are sampled on that pulse.
  - Pulses arriving while ready=0 are dropped.
- cmd 0: key <= {key[71:0], ui_in}. Ten writes load the key; the first byte written becomes K1..K8, with bit7 = K1.
- cmd 1: the same shift into the IV register. First byte is IV1..IV8, bit7 = IV1.
- cmd 2 (start init):
  - Load s1..s93 = K1..K80 followed by 13 zeros.
  - Load s94..s177 = IV1..IV80 followed by 4 zeros.
  - Load s178..s288 = 108 zeros then 1,1,1.
  - ready=0 and init_done=0, then run WARMUP_CYCLES updates with output discarded.
  - Afterwards ready=1 and init_done=1. Cmd 2 while init_done=1 re-initialises.
- Update, one per clock while stepping:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=(s91&s92)^s171; t2^=(s175&s176)^s264; t3^=(s286&s287)^s69.
  - Shift: s1..s93 <= (t3, s1..s92); s94..s177 <= (t1, s94..s176); s178..s288 <= (t2, s178..s287).
- cmd 3 (plaintext):
  - Ignored if init_done=0.
  - Otherwise ready=0; run 8 updates collecting z1..z8 into ks with ks[7]=z1.
  - Ciphertext = ui_in ^ ks, loaded into the transmitter; tx_busy=1.
- Transmitter frame on uo_out[0]: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT clocks; 10 bits total.
  - After the stop bit: tx_busy=0, ready=1, line idles high.
  - The keystream continues across bytes; no re-init between bytes.
- FSM: IDLE -> (cmd2) INIT -> IDLE; IDLE -> (cmd3) KS -> TX -> IDLE. cmd0/1 act in IDLE only.
- Async rst at any point: immediately forces all reset values and drops a partial frame (line goes high).
- Latency: ciphertext start bit begins 8 clocks after the KS state is entered (strobe edge + 2-3 sync cycles).

Decomposition:
- Package trivium_pkg: cmd encodings, state widths (93/84/111), default CLKS_PER_BIT and WARMUP_CYCLES.
- One natural sub-module, trivium_core: 288-bit state, load, step enable, z output.
- UART TX and the control FSM stay in the top.

Test Plan:
- Reset: assert rst -> uo_out=0x03 (tx=1, ready=1), uio_oe=0x00, line stays high for 1000 clocks.
- cmd 3 before init: plaintext 0xA5 -> no start bit, ready stays 1.
- Key = 10x 0x00, IV = 10x 0x00, cmd 2 -> ready low for exactly 1152 cycles (±sync latency), then init_done=1.
  - Encrypt 0x00 -> UART byte equals keystream byte K0, matching a software Trivium model (same bit order).
  - Frame is 10*CLKS_PER_BIT clocks long.
- Encrypt 0x5A, then re-init with the same key/IV and encrypt the received ciphertext -> receiver gets 0x5A back.
- Two consecutive plaintexts 0x00,0x00 -> two different keystream bytes, both equal to model bytes 0 and 1.
- rst pulse mid-frame (after bit 4) -> tx=1 immediately, init_done=0; a strobe during busy is ignored, with no extra frame.
